// File: rtl/cpu_sequencer.sv
// Instruction sequencer for the 8-bit RISC CPU: an 8-state fetch/execute
// cycle plus a HALT state, with strobes decoded from state, opcode and zero.
module cpu_sequencer #(
  parameter int OPCODE_W = 3
) (
  input  logic                clock,
  input  logic                aresetn,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                run,
  output logic                sel,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                load_ir,
  output logic                load_ac,
  output logic                load_pc,
  output logic                inc_pc,
  output logic                halt,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALT       = 4'd8
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

  state_t state_reg, state_next;
  logic   is_hlt, is_skz, is_sto, is_jmp, is_aluop;

  assign is_hlt   = (opcode == OP_HLT);
  assign is_skz   = (opcode == OP_SKZ);
  assign is_sto   = (opcode == OP_STO);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) state_reg <= INST_ADDR;
    else          state_reg <= state_next;
  end

  // Illegal codes fall through to the default and recover into INST_ADDR.
  always_comb begin
    state_next = INST_ADDR;
    case (state_reg)
      INST_ADDR:  state_next = INST_FETCH;
      INST_FETCH: state_next = INST_LOAD;
      INST_LOAD:  state_next = IDLE;
      IDLE:       state_next = OP_ADDR;
      OP_ADDR:    state_next = is_hlt ? HALT : OP_FETCH;
      OP_FETCH:   state_next = ALU_OP;
      ALU_OP:     state_next = STORE;
      STORE:      state_next = INST_ADDR;
      HALT:       state_next = run ? INST_ADDR : HALT;
      default:    state_next = INST_ADDR;
    endcase
  end

  always_comb begin
    sel     = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    halt    = 1'b0;
    case (state_reg)
      INST_ADDR:  sel = 1'b1;
      INST_FETCH: begin sel = 1'b1; mem_rd = 1'b1; end
      INST_LOAD,
      IDLE:       begin sel = 1'b1; mem_rd = 1'b1; load_ir = 1'b1; end
      OP_ADDR:    begin inc_pc = 1'b1; halt = is_hlt; end
      OP_FETCH:   mem_rd = is_aluop;
      ALU_OP: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = is_skz && zero;
        load_pc = is_jmp;
      end
      STORE: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        inc_pc  = is_jmp;
        load_pc = is_jmp;
        mem_wr  = is_sto;
      end
      HALT:       halt = 1'b1;
      default:    ;
    endcase
  end

  assign state = state_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed instructions, halt/resume,
// async reset, then random instruction streams against a phase-based model.
module tb_cpu_sequencer;

  logic       clock = 1'b0;
  logic       aresetn = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       run = 1'b0;
  logic       sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  // Model: position within the 8-step instruction cycle, or parked in halt.
  int   m_phase = 0;
  bit   m_halted = 1'b0;
  bit   m_reset = 1'b1;

  always #5 clock = ~clock;

  cpu_sequencer #(.OPCODE_W(3)) dut (
    .clock   (clock),
    .aresetn (aresetn),
    .opcode  (opcode),
    .zero    (zero),
    .run     (run),
    .sel     (sel),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .load_ir (load_ir),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .inc_pc  (inc_pc),
    .halt    (halt),
    .state   (state)
  );

  // Expected strobes from the instruction-cycle rules: {sel,mem_rd,mem_wr,load_ir,load_ac,load_pc,inc_pc,halt}
  function automatic logic [7:0] expected_strobes(int ph, bit halted, logic [2:0] op, logic z);
    bit aluop;
    logic [7:0] v;
    aluop = (op >= 3'd2) && (op <= 3'd5);
    if (halted) return 8'b0000_0001;
    v[7] = (ph <= 3);
    v[6] = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
    v[5] = (ph == 7) && (op == 3'd6);
    v[4] = (ph == 2) || (ph == 3);
    v[3] = (ph >= 6) && aluop;
    v[2] = (ph >= 6) && (op == 3'd7);
    v[1] = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
    v[0] = (ph == 4) && (op == 3'd0);
    return v;
  endfunction

  task automatic check(input string tag);
    logic [7:0] exp_v, obs_v;
    logic [3:0] exp_s;
    exp_s = m_halted ? 4'd8 : 4'(m_phase);
    exp_v = expected_strobes(m_phase, m_halted, opcode, zero);
    obs_v = {sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt};
    checks++;
    assert (state === exp_s) else begin
      errors++;
      $error("FAIL %s.state op=%0d got=%0d want=%0d", tag, opcode, state, exp_s);
    end
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s.strobes state=%0d op=%0d z=%0b got=%b want=%b", tag, exp_s, opcode, zero, obs_v, exp_v);
    end
    $display("check %s: state=%0d op=%0d z=%0b run=%0b strobes=%b", tag, state, opcode, zero, run, obs_v);
  endtask

  // One clock: apply inputs, check mid-cycle, then advance the model on the edge.
  task automatic cycle(input logic [2:0] op, input logic z, input logic r, input string tag);
    opcode = op; zero = z; run = r;
    @(negedge clock);
    check(tag);
    @(posedge clock);
    if (m_halted) begin
      if (r) begin m_halted = 1'b0; m_phase = 0; end
    end else if (m_phase == 4 && op == 3'd0) begin
      m_halted = 1'b1;
    end else begin
      m_phase = (m_phase + 1) % 8;
    end
    #1;
  endtask

  // Run until the instruction completes (back to phase 0) or halts.
  task automatic instr(input logic [2:0] op, input bit rand_z, input logic z, input string tag);
    int guard;
    guard = 0;
    do begin
      cycle(op, rand_z ? logic'($urandom_range(0, 1)) : z, logic'($urandom_range(0, 1)), tag);
      guard++;
    end while (!(m_phase == 0 || m_halted) && guard < 9);
  endtask

  // Assert reset now, hold n edges, release between edges; leaves model one edge past release.
  task automatic do_reset(input int n, input string tag);
    aresetn = 1'b0;
    m_phase = 0; m_halted = 1'b0;
    #1;
    check({tag, ".assert"});
    repeat (n) begin
      @(posedge clock); #1;
      check({tag, ".hold"});
    end
    @(negedge clock);
    aresetn = 1'b1;
    #1;
    check({tag, ".release"});
    @(posedge clock); #1;
    m_phase = 1;
  endtask

  initial begin
    do_reset(3, "reset");
    cycle(3'd5, 1'b0, 1'b0, "after_reset");
    instr(3'd5, 1'b0, 1'b0, "finish_first");

    instr(3'd5, 1'b1, 1'b0, "lda");
    instr(3'd1, 1'b0, 1'b1, "skz_z1");
    instr(3'd1, 1'b0, 1'b0, "skz_z0");
    instr(3'd7, 1'b1, 1'b0, "jmp");
    instr(3'd6, 1'b1, 1'b0, "sto");
    instr(3'd2, 1'b1, 1'b0, "add");

    // HLT with run asserted in the entry cycle: must still park.
    repeat (4) cycle(3'd0, 1'b0, 1'b0, "hlt");
    cycle(3'd0, 1'b0, 1'b1, "hlt_entry_run");
    repeat (10) cycle(3'd0, 1'b0, 1'b0, "halted");
    cycle(3'd0, 1'b0, 1'b1, "resume");
    cycle(3'd4, 1'b0, 1'b0, "after_resume");
    instr(3'd4, 1'b1, 1'b0, "xor");

    // Reset in the middle of a store, during ALU_OP.
    repeat (6) cycle(3'd6, 1'b0, 1'b0, "sto_partial");
    #1;
    do_reset(2, "mid_reset");
    opcode = 3'd6;
    instr(3'd6, 1'b1, 1'b0, "post_reset");

    // Random instruction stream; halts resume after a random wait.
    for (int i = 0; i < 60; i++) begin
      instr(3'($urandom_range(0, 7)), 1'b1, 1'b0, "rand");
      if (m_halted) begin
        repeat ($urandom_range(0, 4)) cycle(3'($urandom_range(0, 7)), logic'($urandom_range(0, 1)), 1'b0, "rand_halt");
        cycle(3'($urandom_range(0, 7)), logic'($urandom_range(0, 1)), 1'b1, "rand_run");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout state=%0d", state);
    $fatal(1, "timeout");
  end

endmodule
